// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Holds the program counter and a small instruction memory. The memory is
// written by the debug unit's program loader and read with zero latency at the
// current PC. A two-state FSM (RUN / HALTED) stops fetching after an all-ones
// HALT word has been fetched and advanced. Only a reset leaves HALTED.
//
// Parameters
//   DATA_WIDTH  instruction / PC width (default 32)
//   MEM_DEPTH   instruction memory depth in words (default 64, power of two)
//   ADDR_W      derived: $clog2(MEM_DEPTH)
//
// Ports
//   i_clock          single clock, all state updates on the rising edge
//   i_reset          synchronous, active-high reset
//   i_enable         run enable from the debug unit (continuous or single step)
//   i_if_id_burbuja  stall from the hazard unit, PC is held
//   i_pc_src         take the branch/jump redirect on i_pc_target
//   i_pc_target      redirect byte address
//   i_wr_en          program-load write strobe
//   i_wr_addr        program-load word address
//   i_wr_data        program-load word
//   o_instruccion    fetched instruction toward IF_ID (0 while halted)
//   o_pc             PC+4 of the fetched instruction toward IF_ID
//   o_halt           high while the FSM is in HALTED
//   o_fetch_count    number of instructions fetched and advanced (wraps)
//   o_dbg_state      FSM state (0 = RUN, 1 = HALTED) for debug and checkers
//
// Configuration
//   IF_STAGE_FLUSH_EN  when defined, the fetched word is squashed to 0 in any
//                      cycle where a redirect is taken (wrong-path squash).
//                      When undefined the fetched word passes unchanged, which
//                      gives delay-slot semantics.
//
// Handshake: there is no valid/ready pair. A fetch "advances" on every rising
// edge where the FSM is in RUN, i_enable is high and i_if_id_burbuja is low;
// in any other cycle the PC and the fetch counter are held.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter int  DATA_WIDTH = 32,
    parameter int  MEM_DEPTH  = 64,
    localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_if_id_burbuja,
    input  logic                  i_pc_src,
    input  logic [DATA_WIDTH-1:0] i_pc_target,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_halt,
    output logic [31:0]           o_fetch_count,
    output logic                  o_dbg_state
);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   pc_next;
    logic [ADDR_W-1:0]       rd_idx;
    logic [DATA_WIDTH-1:0]   fetched;
    logic                    advance;
    logic                    halt_hit;
    logic                    squash;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // -------------------------------------------------------------------------
    // Fetch datapath
    // -------------------------------------------------------------------------
    // Word index drops the byte offset; the upper PC bits are simply ignored,
    // so any PC beyond the memory wraps modulo MEM_DEPTH.
    assign rd_idx   = pc[ADDR_W+1:2];
    assign fetched  = mem[rd_idx];
    assign pc_plus4 = pc + DATA_WIDTH'(4);

    assign advance  = (state == ST_RUN) && i_enable && !i_if_id_burbuja;

    // A taken redirect outranks the HALT word: the HALT sits on the wrong path
    // (or in the delay slot) and must not stop the machine.
    assign halt_hit = advance && !i_pc_src && (fetched == {DATA_WIDTH{1'b1}});

`ifdef IF_STAGE_FLUSH_EN
    assign squash = advance && i_pc_src;
`else
    assign squash = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // PC next-value selection, highest priority first:
    //   halted > disabled > stalled > redirect > HALT fetched > sequential
    // A redirect that arrives during a stall is dropped on purpose; the
    // decode stage keeps asserting it until the stall clears.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_next = pc_plus4;
        if (state == ST_HALTED) begin
            pc_next = pc;
        end else if (!i_enable) begin
            pc_next = pc;
        end else if (i_if_id_burbuja) begin
            pc_next = pc;
        end else if (i_pc_src) begin
            pc_next = i_pc_target;
        end else if (halt_hit) begin
            // PC stays on the HALT word so o_pc keeps showing its PC+4.
            pc_next = pc;
        end
    end

    // -------------------------------------------------------------------------
    // FSM, PC and fetch counter. Reset wins over every PC update, including
    // stalls and redirects in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= ST_RUN;
            pc            <= '0;
            o_fetch_count <= '0;
        end else begin
            pc <= pc_next;
            if (advance) begin
                // The HALT fetch itself is counted.
                o_fetch_count <= o_fetch_count + 32'd1;
            end
            case (state)
                ST_RUN: begin
                    if (halt_hit) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Program-load port. Memory has no reset so a program survives a reset,
    // and loads are accepted in any state. A write to the word currently being
    // fetched shows the old word this cycle and the new one from the next.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_instruccion = fetched;
        if (state == ST_HALTED || squash) begin
            o_instruccion = '0;
        end
    end

    assign o_pc        = pc_plus4;
    assign o_halt      = (state == ST_HALTED);
    assign o_dbg_state = state;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- directed bench for if_stage (DATA_WIDTH=32, MEM_DEPTH=64)
//
// Inputs are driven 1 time unit after the rising edge; for every cycle the
// expected outputs are pushed to a queue at drive time and popped/compared on
// the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam int W  = 32;
    localparam int AW = 6;

    logic          i_clock;
    logic          i_reset;
    logic          i_enable;
    logic          i_if_id_burbuja;
    logic          i_pc_src;
    logic [W-1:0]  i_pc_target;
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [W-1:0]  i_wr_data;
    logic [W-1:0]  o_instruccion;
    logic [W-1:0]  o_pc;
    logic          o_halt;
    logic [31:0]   o_fetch_count;
    logic          o_dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_instr_q[$];
    logic [W-1:0] exp_pc_q[$];
    logic [W-1:0] exp_halt_q[$];
    logic [W-1:0] exp_cnt_q[$];

    if_stage #(.DATA_WIDTH(W), .MEM_DEPTH(64)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_if_id_burbuja (i_if_id_burbuja),
        .i_pc_src        (i_pc_src),
        .i_pc_target     (i_pc_target),
        .i_wr_en         (i_wr_en),
        .i_wr_addr       (i_wr_addr),
        .i_wr_data       (i_wr_data),
        .o_instruccion   (o_instruccion),
        .o_pc            (o_pc),
        .o_halt          (o_halt),
        .o_fetch_count   (o_fetch_count),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic stall, input logic src,
                         input logic [W-1:0] tgt);
        i_enable        = en;
        i_if_id_burbuja = stall;
        i_pc_src        = src;
        i_pc_target     = tgt;
    endtask

    task automatic load(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        i_wr_en   = we;
        i_wr_addr = a;
        i_wr_data = d;
    endtask

    // Expected value of o_instruccion in a cycle where a redirect is taken.
    function automatic logic [W-1:0] redirect_word(input logic [W-1:0] w);
`ifdef IF_STAGE_FLUSH_EN
        return '0;
`else
        return w;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic expect_out(input logic [W-1:0] instr, input logic [W-1:0] pc,
                              input logic halt, input logic [31:0] cnt);
        exp_instr_q.push_back(instr);
        exp_pc_q.push_back(pc);
        exp_halt_q.push_back(W'(halt));
        exp_cnt_q.push_back(cnt);
    endtask

    task automatic check_one(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits to the falling edge of the current cycle and compares all outputs.
    task automatic check_cycle(input string tag);
        @(negedge i_clock);
        if (exp_instr_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_queue: observed empty expected nonempty", tag);
        end else begin
            check_one({tag, "_instr"}, o_instruccion, exp_instr_q.pop_front());
            check_one({tag, "_pc"},    o_pc,          exp_pc_q.pop_front());
            check_one({tag, "_halt"},  W'(o_halt),    exp_halt_q.pop_front());
            check_one({tag, "_cnt"},   o_fetch_count, exp_cnt_q.pop_front());
        end
    endtask

    // One cycle: drive, record expectation, compare, advance to next edge.
    task automatic step(input string tag, input logic en, input logic stall,
                        input logic src, input logic [W-1:0] tgt,
                        input logic [W-1:0] e_instr, input logic [W-1:0] e_pc,
                        input logic e_halt, input logic [31:0] e_cnt);
        drive(en, stall, src, tgt);
        expect_out(e_instr, e_pc, e_halt, e_cnt);
        check_cycle(tag);
        next_cycle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        i_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        load(1'b0, '0, '0);
        next_cycle();

        // Program load while reset is held.
        load(1'b1, 6'd0,  32'h0000_0011); next_cycle();
        load(1'b1, 6'd1,  32'h0000_0022); next_cycle();
        load(1'b1, 6'd2,  32'h0000_0033); next_cycle();
        load(1'b1, 6'd3,  32'hFFFF_FFFF); next_cycle();
        load(1'b1, 6'd16, 32'h0000_0044); next_cycle();
        load(1'b1, 6'd17, 32'h0000_0055); next_cycle();
        load(1'b0, '0, '0);
        i_reset = 1'b0;

        // Reset state, disabled.
        step("rst",    1'b0, 1'b0, 1'b0, '0, 32'h11, 32'd4, 1'b0, 32'd0);

        // Sequential fetch.
        step("seq0",   1'b1, 1'b0, 1'b0, '0, 32'h11, 32'd4, 1'b0, 32'd0);
        step("seq1",   1'b1, 1'b0, 1'b0, '0, 32'h22, 32'd8, 1'b0, 32'd1);

        // Two stalled cycles at PC=8 with a redirect pending: PC and count hold.
        step("stall0", 1'b1, 1'b1, 1'b1, 32'h40, 32'h33, 32'd12, 1'b0, 32'd2);
        step("stall1", 1'b1, 1'b1, 1'b1, 32'h40, 32'h33, 32'd12, 1'b0, 32'd2);
        // Stall released, redirect re-asserted.
        step("redir",  1'b1, 1'b0, 1'b1, 32'h40, redirect_word(32'h33), 32'd12, 1'b0, 32'd2);
        step("tgt40",  1'b1, 1'b0, 1'b0, '0, 32'h44, 32'h44, 1'b0, 32'd3);

        // Redirect beyond the memory wraps to index 0.
        step("redir2", 1'b1, 1'b0, 1'b1, 32'h100, redirect_word(32'h55), 32'h48, 1'b0, 32'd4);
        step("wrap",   1'b1, 1'b0, 1'b0, '0, 32'h11, 32'h104, 1'b0, 32'd5);
        step("redir3", 1'b1, 1'b0, 1'b1, 32'h4, redirect_word(32'h22), 32'h108, 1'b0, 32'd6);
        // Redirect at PC=4 while 0x22 is fetched.
        step("flush",  1'b1, 1'b0, 1'b1, 32'h8, redirect_word(32'h22), 32'd8, 1'b0, 32'd7);

        // Disabled for 5 cycles at PC=8; overwrite the current word mid-way.
        step("dis0",   1'b0, 1'b0, 1'b0, '0, 32'h33, 32'd12, 1'b0, 32'd8);
        step("dis1",   1'b0, 1'b0, 1'b0, '0, 32'h33, 32'd12, 1'b0, 32'd8);
        load(1'b1, 6'd2, 32'h0000_0066);
        step("dis2wr", 1'b0, 1'b0, 1'b0, '0, 32'h33, 32'd12, 1'b0, 32'd8);
        load(1'b0, '0, '0);
        step("dis3",   1'b0, 1'b0, 1'b0, '0, 32'h66, 32'd12, 1'b0, 32'd8);
        step("dis4",   1'b0, 1'b0, 1'b0, '0, 32'h66, 32'd12, 1'b0, 32'd8);

        // Resume and reach the HALT word.
        step("resume", 1'b1, 1'b0, 1'b0, '0, 32'h66, 32'd12, 1'b0, 32'd8);
        step("hword",  1'b1, 1'b0, 1'b0, '0, 32'hFFFF_FFFF, 32'd16, 1'b0, 32'd9);
        step("halt0",  1'b1, 1'b0, 1'b0, '0, 32'h0, 32'd16, 1'b1, 32'd10);
        // Redirect and a program-load write while halted: neither moves the PC.
        load(1'b1, 6'd3, 32'h0000_0077);
        step("halt1",  1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'd16, 1'b1, 32'd10);
        load(1'b0, '0, '0);
        step("halt2",  1'b1, 1'b0, 1'b0, '0, 32'h0, 32'd16, 1'b1, 32'd10);

        // Reset while a stall and a redirect are both asserted.
        i_reset = 1'b1;
        step("halt3",  1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 32'd16, 1'b1, 32'd10);
        i_reset = 1'b0;
        step("rst2",   1'b0, 1'b0, 1'b0, '0, 32'h11, 32'd4, 1'b0, 32'd0);

        // Memory survived reset; word 3 holds the write made while halted.
        step("run0",   1'b1, 1'b0, 1'b0, '0, 32'h11, 32'd4,  1'b0, 32'd0);
        step("run1",   1'b1, 1'b0, 1'b0, '0, 32'h22, 32'd8,  1'b0, 32'd1);
        step("run2",   1'b1, 1'b0, 1'b0, '0, 32'h66, 32'd12, 1'b0, 32'd2);
        step("run3",   1'b1, 1'b0, 1'b0, '0, 32'h77, 32'd16, 1'b0, 32'd3);

        // ---------------- final report ----------------
        if (exp_instr_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL leftover: observed %0d expected 0", exp_instr_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog: the sequence is short; this only fires if something hangs.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/PC width.
REQ-002 Parameter MEM_DEPTH, default 64, instruction memory depth in words; ADDR_W = clog2(MEM_DEPTH).
REQ-003 i_clock  input  1  single clock, all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_enable  input  1  run enable from debug unit (continuous or single-step).
REQ-006 i_if_id_burbuja  input  1  stall from hazard unit; hold PC.
REQ-007 i_pc_src  input  1  take branch/jump redirect.
REQ-008 i_pc_target  input  DATA_WIDTH  redirect byte address.
REQ-009 i_wr_en  input  1  program-load write strobe.
REQ-010 i_wr_addr  input  ADDR_W  program-load word address.
REQ-011 i_wr_data  input  DATA_WIDTH  program-load word.
REQ-012 o_instruccion  output  DATA_WIDTH  fetched instruction toward IF_ID.
REQ-013 o_pc  output  DATA_WIDTH  PC+4 of fetched instruction toward IF_ID.
REQ-014 o_halt  output  1  high while in HALTED.
REQ-015 o_fetch_count  output  32  count of instructions fetched and advanced.

Function
REQ-016 PC register SHALL hold a byte address; memory word index = PC[ADDR_W+1:2]; PC[1:0] ignored; index wraps modulo MEM_DEPTH.
REQ-017 Memory read SHALL be asynchronous: o_instruccion = mem[index(PC)] in same cycle (zero latency); o_pc = PC+4, modulo 2^DATA_WIDTH.
REQ-018 Writes SHALL be synchronous: mem[i_wr_addr] <= i_wr_data on edge when i_wr_en; new data visible from next cycle; write to current index SHALL show old word this cycle.
REQ-019 FSM states RUN, HALTED; RUN->HALTED when advance condition (REQ-021) holds and fetched word = all ones (HALT) and i_pc_src low; HALTED exits only via reset.
REQ-020 PC next-value priority: HALTED hold > !i_enable hold > i_if_id_burbuja hold > i_pc_src load i_pc_target > HALT detected hold > PC+4.
REQ-021 Advance condition = RUN & i_enable & !i_if_id_burbuja.
REQ-022 Stall with simultaneous i_pc_src SHALL hold PC; redirect not latched (ID re-asserts after stall).
REQ-023 In HALTED o_instruccion SHALL be 0 (NOP) and o_pc SHALL hold last value PC+4 of the HALT word.
REQ-024 o_fetch_count SHALL increment by 1 on each edge where advance condition holds, including the HALT fetch; wraps 2^32-1 -> 0.
REQ-025 Program-load writes SHALL be accepted in any state, including HALTED and during reset.

Reset
REQ-026 On i_reset edge: PC = 0, state = RUN, o_fetch_count = 0; so o_pc = 4, o_halt = 0, o_instruccion = mem[0].
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 Reset mid-stall or mid-redirect SHALL take priority over all PC updates.

Configuration
REQ-029 Macro IF_STAGE_FLUSH_EN: when defined, o_instruccion SHALL be forced to 0 in any cycle with i_pc_src high and advance condition true (wrong-path squash); when undefined, fetched word passes unchanged (delay-slot semantics).

Verification
REQ-030 Load words 0x11,0x22,0x33 at 0..2, reset, enable -> o_pc 4,8,12 and o_instruccion 0x11,0x22,0x33 on successive cycles; count 1,2,3.
REQ-031 Stall 2 cycles at PC=8 with i_pc_src=1, target 0x40 -> PC holds 8, count unchanged; stall released, pc_src=1 -> next PC 0x40.
REQ-032 HALT word 0xFFFFFFFF at index 3 -> after fetch o_halt=1, o_instruccion=0, o_pc=16 held indefinitely, count frozen; reset -> o_pc=4, o_halt=0.
REQ-033 Redirect to 0x100 with MEM_DEPTH=64 -> index 0 fetched (wrap), o_pc=0x104.
REQ-034 IF_STAGE_FLUSH_EN defined, pc_src=1 at PC=4 holding 0x22 -> o_instruccion=0 that cycle; undefined -> 0x22.
REQ-035 i_enable=0 for 5 cycles mid-program -> PC and count constant; write to current index -> new word visible next cycle.
